// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared constants and state type for the Montgomery datapath
package rsa_pkg;

    localparam int RSA_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } mont_state_e;

endpackage

// File: rtl/mont_step.sv
// rtl/mont_step.sv - one radix-2 Montgomery iteration: (r + bit*b + q*n) / 2
module mont_step #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH:0]   r,
    input  logic             a_bit,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH:0]   r_next
);

    logic [WIDTH+1:0] s;
    logic [WIDTH+1:0] t;

    // r < 2n and b < n keep s + n below 4n, so WIDTH+2 bits cannot overflow
    always_comb begin
        s      = {1'b0, r} + {2'b00, (a_bit ? b : '0)};
        t      = s + (s[0] ? {2'b00, n} : '0);
        r_next = t[WIDTH+1:1];
    end

endmodule

// File: rtl/mont_loop_datapath.sv
// rtl/mont_loop_datapath.sv - iterating radix-2 Montgomery multiplier stepped by an external loop controller
module mont_loop_datapath
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cen,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_n,
    input  logic             o_cen,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mont_state_e      state;
    mont_state_e      state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH:0]   r;
    logic [WIDTH:0]   r_step;
    logic [WIDTH:0]   r_corr;
    logic [WIDTH-1:0] a_shift;
    logic [CNT_W-1:0] cnt;
    logic             last_iter;

    assign a_shift   = a_q >> cnt;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign r_corr    = (r >= {1'b0, n_q}) ? (r - {1'b0, n_q}) : r;

    mont_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r      (r),
        .a_bit  (a_shift[0]),
        .b      (b_q),
        .n      (n_q),
        .r_next (r_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A load always wins over a step issued in the same cycle
    always_comb begin
        state_next = state;
        if (i_cen) begin
            state_next = ITER;
        end else if (o_cen) begin
            case (state)
                ITER:    if (last_iter) state_next = CORR;
                CORR:    state_next = DONE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            n_q <= '0;
            r   <= '0;
            cnt <= '0;
        end else if (i_cen) begin
            a_q <= i_a;
            b_q <= i_b;
            n_q <= i_n;
            r   <= '0;
            cnt <= '0;
        end else if (o_cen && (state == ITER)) begin
            r   <= r_step;
            cnt <= cnt + CNT_W'(1);
        end else if (o_cen && (state == CORR)) begin
            r   <= r_corr;
        end
    end

    assign o_done   = (state == DONE);
    assign o_result = r[WIDTH-1:0];

endmodule
